hazard_unit_mc: RTL and testbench

- Parametrised successor hazard unit for the 5-stage pipeline (F/D/E/M/W).
- Compares register indices internally instead of taking pre-computed match strobes.
- Supports NSRC source operands per instruction and an optional hard-wired zero register.
- Adds a variable-latency memory-wait state machine with timeout, a sticky timeout error, and a saturating stall-cycle performance counter.

---
 rtl/hazard_pkg.sv | 14 +
 rtl/hazard_fwd_sel.sv | 31 +++
 rtl/hazard_unit_mc.sv | 120 ++++++++++++
 tb/tb_hazard_unit_mc.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings and register-index compare for the hazard unit
package hazard_pkg;
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic {RUN = 1'b0, WAIT = 1'b1} state_t;

    // Indices are zero-extended by the caller so one helper serves every width.
    function automatic logic reg_match(input logic [31:0] idx, input logic [31:0] wa,
                                       input logic valid, input logic we, input logic zero_reg);
        return valid && we && (idx == wa) && !(zero_reg && (idx == 32'd0));
    endfunction
endpackage

// File: rtl/hazard_fwd_sel.sv
// rtl/hazard_fwd_sel.sv - per-operand forward select from the M and W stages
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int RIDX_W   = 4,
    parameter int ZERO_REG = 0
) (
    input  logic [RIDX_W-1:0] i_ra,
    input  logic              i_ra_valid,
    input  logic [RIDX_W-1:0] i_wa_m,
    input  logic              i_we_m,
    input  logic              i_memtoreg_m,
    input  logic [RIDX_W-1:0] i_wa_w,
    input  logic              i_we_w,
    output logic [1:0]        o_fwd
);
    logic w_hit_m;
    logic w_hit_w;

    always_comb begin
        w_hit_m = reg_match(32'(i_ra), 32'(i_wa_m), i_ra_valid, i_we_m, ZERO_REG != 0);
        w_hit_w = reg_match(32'(i_ra), 32'(i_wa_w), i_ra_valid, i_we_w, ZERO_REG != 0);
        o_fwd   = FWD_RF;
        // A load still in M has no data yet; the load-use stall lets it arrive via W.
        if (w_hit_m && !i_memtoreg_m) begin
            o_fwd = FWD_M;
        end else if (w_hit_w) begin
            o_fwd = FWD_W;
        end
    end
endmodule

// File: rtl/hazard_unit_mc.sv
// rtl/hazard_unit_mc.sv - pipeline hazard unit with forwarding, load-use stall and memory-wait FSM
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int RIDX_W   = 4,
    parameter int NSRC     = 3,
    parameter int ZERO_REG = 0,
    parameter int TIMEOUT  = 255,
    parameter int CNT_W    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NSRC*RIDX_W-1:0] RA_D,
    input  logic [NSRC-1:0]        RAValidD,
    input  logic [NSRC*RIDX_W-1:0] RA_E,
    input  logic [NSRC-1:0]        RAValidE,
    input  logic [RIDX_W-1:0]      WA_E,
    input  logic [RIDX_W-1:0]      WA_M,
    input  logic [RIDX_W-1:0]      WA_W,
    input  logic                   RegWriteE,
    input  logic                   RegWriteM,
    input  logic                   RegWriteW,
    input  logic                   MemtoRegE,
    input  logic                   MemtoRegM,
    input  logic                   MemAccessM,
    input  logic                   MemReadyM,
    input  logic                   BranchTakenD,
    input  logic                   PredictionD,
    input  logic                   PCSrcW,
    input  logic                   PCWrPendingF,
    output logic [2*NSRC-1:0]      ForwardE,
    output logic                   StallF,
    output logic                   StallD,
    output logic                   StallE,
    output logic                   StallM,
    output logic                   FlushD,
    output logic                   FlushE,
    output logic                   FlushW,
    output logic                   MemErr,
    output logic [CNT_W-1:0]       StallCount
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

    state_t            r_state;
    logic [CW-1:0]     r_wcnt;
    logic              r_mem_err;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic [2*NSRC-1:0] w_fwd;
    logic [NSRC-1:0]   w_ld_hit;
    logic              w_ld_stall;
    logic              w_mem_stall;
    logic              w_abort;

    for (genvar g = 0; g < NSRC; g++) begin : g_fwd
        hazard_fwd_sel #(
            .RIDX_W  (RIDX_W),
            .ZERO_REG(ZERO_REG)
        ) u_fwd_sel (
            .i_ra        (RA_E[g*RIDX_W +: RIDX_W]),
            .i_ra_valid  (RAValidE[g]),
            .i_wa_m      (WA_M),
            .i_we_m      (RegWriteM),
            .i_memtoreg_m(MemtoRegM),
            .i_wa_w      (WA_W),
            .i_we_w      (RegWriteW),
            .o_fwd       (w_fwd[2*g +: 2])
        );
    end

    always_comb begin
        w_ld_hit = '0;
        for (int i = 0; i < NSRC; i++) begin
            w_ld_hit[i] = reg_match(32'(RA_D[i*RIDX_W +: RIDX_W]), 32'(WA_E),
                                    RAValidD[i], RegWriteE, ZERO_REG != 0);
        end
        w_ld_stall = MemtoRegE && (|w_ld_hit);
        // The entry cycle stalls combinationally; the abort cycle behaves as a ready cycle.
        w_mem_stall = ((r_state == RUN) && MemAccessM && !MemReadyM) ||
                      ((r_state == WAIT) && !MemReadyM && (r_wcnt != TO_CNT));
        w_abort     = (r_state == WAIT) && !MemReadyM && (r_wcnt == TO_CNT);
    end

    always_comb begin
        ForwardE   = reset ? w_fwd : '0;
        StallF     = reset && (w_mem_stall || w_ld_stall || PCWrPendingF);
        StallD     = reset && (w_mem_stall || w_ld_stall);
        StallE     = reset && w_mem_stall;
        StallM     = reset && w_mem_stall;
        FlushW     = reset && w_mem_stall;
        FlushE     = reset && !w_mem_stall && w_ld_stall;
        FlushD     = reset && !w_mem_stall && (PCWrPendingF || PCSrcW || (BranchTakenD ^ PredictionD));
        MemErr     = r_mem_err;
        StallCount = r_stall_cnt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= RUN;
            r_wcnt      <= '0;
            r_mem_err   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (w_mem_stall) begin
                r_state <= WAIT;
                r_wcnt  <= (r_state == RUN) ? CW'(1) : r_wcnt + 1'b1;
            end else begin
                r_state <= RUN;
                r_wcnt  <= '0;
            end
            if (w_abort) begin
                r_mem_err <= 1'b1;
            end
            if ((StallF || StallD) && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb/tb_hazard_unit_mc.sv - randomized self-checking bench for hazard_unit_mc
module tb_hazard_unit_mc;
    localparam int TMO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [11:0] ra_d, ra_e;
    logic [2:0]  vd, ve;
    logic [3:0]  wa_e, wa_m, wa_w;
    logic        rwe, rwm, rww, mtre, mtrm, macc, mrdy, btk, pred, pcsrc, pcwp;

    logic [5:0]  fwd [2];
    logic        sf[2], sd[2], se[2], sm[2], fd[2], fe[2], fw[2], me[2];
    logic [31:0] cnt0;
    logic [5:0]  cnt1;

    int n_cmp = 0;
    int n_err = 0;

    bit     m_wait = 1'b0;
    int     m_nst  = 0;
    bit     m_err  = 1'b0;
    longint m_cnt[2] = '{0, 0};

    hazard_unit_mc #(.RIDX_W(4), .NSRC(3), .ZERO_REG(0), .TIMEOUT(TMO), .CNT_W(32)) u_dut0 (
        .clk(clk), .reset(reset), .RA_D(ra_d), .RAValidD(vd), .RA_E(ra_e), .RAValidE(ve),
        .WA_E(wa_e), .WA_M(wa_m), .WA_W(wa_w), .RegWriteE(rwe), .RegWriteM(rwm), .RegWriteW(rww),
        .MemtoRegE(mtre), .MemtoRegM(mtrm), .MemAccessM(macc), .MemReadyM(mrdy),
        .BranchTakenD(btk), .PredictionD(pred), .PCSrcW(pcsrc), .PCWrPendingF(pcwp),
        .ForwardE(fwd[0]), .StallF(sf[0]), .StallD(sd[0]), .StallE(se[0]), .StallM(sm[0]),
        .FlushD(fd[0]), .FlushE(fe[0]), .FlushW(fw[0]), .MemErr(me[0]), .StallCount(cnt0)
    );

    hazard_unit_mc #(.RIDX_W(4), .NSRC(3), .ZERO_REG(1), .TIMEOUT(TMO), .CNT_W(6)) u_dut1 (
        .clk(clk), .reset(reset), .RA_D(ra_d), .RAValidD(vd), .RA_E(ra_e), .RAValidE(ve),
        .WA_E(wa_e), .WA_M(wa_m), .WA_W(wa_w), .RegWriteE(rwe), .RegWriteM(rwm), .RegWriteW(rww),
        .MemtoRegE(mtre), .MemtoRegM(mtrm), .MemAccessM(macc), .MemReadyM(mrdy),
        .BranchTakenD(btk), .PredictionD(pred), .PCSrcW(pcsrc), .PCWrPendingF(pcwp),
        .ForwardE(fwd[1]), .StallF(sf[1]), .StallD(sd[1]), .StallE(se[1]), .StallM(sm[1]),
        .FlushD(fd[1]), .FlushE(fe[1]), .FlushW(fw[1]), .MemErr(me[1]), .StallCount(cnt1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit hit(input logic [3:0] idx, input logic v, input logic [3:0] wa,
                               input logic we, input bit zr);
        return v && we && (idx == wa) && !(zr && idx == 4'd0);
    endfunction

    task automatic clr();
        ra_d = '0; ra_e = '0; vd = '0; ve = '0; wa_e = '0; wa_m = '0; wa_w = '0;
        rwe = 0; rwm = 0; rww = 0; mtre = 0; mtrm = 0; macc = 0; mrdy = 0;
        btk = 0; pred = 0; pcsrc = 0; pcwp = 0;
    endtask

    always @(negedge clk) begin : cmp
        bit          memstall, abort, ld, fdx;
        logic [5:0]  efwd;
        logic [7:0]  ectl, actl;
        longint      emax, acnt;
        for (int k = 0; k < 2; k++) begin
            actl = {sf[k], sd[k], se[k], sm[k], fd[k], fe[k], fw[k], me[k]};
            acnt = (k == 0) ? longint'(cnt0) : longint'(cnt1);
            if (!reset) begin
                check("reset_ctl", 64'(actl), 64'd0);
                check("reset_fwd", 64'(fwd[k]), 64'd0);
                check("reset_cnt", 64'(acnt), 64'd0);
            end else begin
                memstall = m_wait ? (!mrdy && m_nst < TMO) : (macc && !mrdy);
                ld = 1'b0;
                efwd = '0;
                for (int i = 0; i < 3; i++) begin
                    if (mtre && hit(ra_d[4*i +: 4], vd[i], wa_e, rwe, k == 1)) ld = 1'b1;
                    if (hit(ra_e[4*i +: 4], ve[i], wa_m, rwm, k == 1) && !mtrm) efwd[2*i +: 2] = 2'b10;
                    else if (hit(ra_e[4*i +: 4], ve[i], wa_w, rww, k == 1))    efwd[2*i +: 2] = 2'b01;
                end
                fdx = pcwp || pcsrc || (btk != pred);
                if (memstall) ectl = {4'b1111, 1'b0, 1'b0, 1'b1, m_err};
                else          ectl = {ld || pcwp, ld, 1'b0, 1'b0, fdx, ld, 1'b0, m_err};
                check("ctl", 64'(actl), 64'(ectl));
                check("fwd", 64'(fwd[k]), 64'(efwd));
                check("cnt", 64'(acnt), 64'(m_cnt[k]));
                emax = (k == 0) ? 64'hFFFF_FFFF : 64'd63;
                if ((ectl[7] || ectl[6]) && m_cnt[k] < emax) m_cnt[k]++;
            end
        end
        if (!reset) begin
            m_wait = 0; m_nst = 0; m_err = 0; m_cnt[0] = 0; m_cnt[1] = 0;
        end else begin
            memstall = m_wait ? (!mrdy && m_nst < TMO) : (macc && !mrdy);
            abort    = m_wait && !mrdy && m_nst >= TMO;
            if (memstall) begin
                m_nst  = m_wait ? m_nst + 1 : 1;
                m_wait = 1;
            end else begin
                m_wait = 0;
                m_nst  = 0;
            end
            if (abort) m_err = 1;
        end
    end

    initial begin
        int pct;
        reset = 1'b0;
        clr();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1 check("lit_reset_cnt", 64'(cnt0), 64'd0);
        check("lit_reset_err", 64'(me[0]), 64'd0);

        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            macc = 1; mrdy = 0; btk = 1; pred = 0;
            #1 check("lit_wait_stall", 64'({sf[0], sd[0], se[0], sm[0], fw[0]}), 64'h1f);
            check("lit_wait_flushd", 64'(fd[0]), 64'd0);
        end
        @(posedge clk); #1 mrdy = 1;
        #1 check("lit_release_stall", 64'(sm[0]), 64'd0);
        check("lit_release_flushd", 64'(fd[0]), 64'd1);
        @(posedge clk); #1 clr();
        #1 check("lit_wait_cnt0", 64'(cnt0), 64'd4);
        check("lit_wait_cnt1", 64'(cnt1), 64'd4);

        for (int c = 0; c < TMO; c++) begin
            @(posedge clk); #1 macc = 1; mrdy = 0;
            #1 check("lit_timeout_stall", 64'(sm[1]), 64'd1);
        end
        @(posedge clk); #1;
        #1 check("lit_abort_release", 64'({sf[1], sm[1]}), 64'd0);
        check("lit_abort_err_pre", 64'(me[1]), 64'd0);
        @(posedge clk); #1 clr();
        #1 check("lit_memerr_set", 64'(me[1]), 64'd1);
        @(posedge clk); #1;
        #1 check("lit_memerr_sticky", 64'(me[0]), 64'd1);
        check("lit_timeout_cnt", 64'(cnt0), 64'd12);

        @(posedge clk); #1 macc = 1; mrdy = 0; ra_e[3:0] = 4'd3; ve = 3'b001; wa_m = 4'd3; rwm = 1;
        #1 check("lit_rst_pre_stall", 64'(sm[0]), 64'd1);
        check("lit_rst_pre_fwd", 64'(fwd[0]), 64'h2);
        #1 reset = 1'b0;
        #1 check("lit_async_ctl", 64'({sf[0], sd[0], se[0], sm[0], fd[0], fe[0], fw[0], me[0]}), 64'd0);
        check("lit_async_fwd", 64'(fwd[0]), 64'd0);
        check("lit_async_cnt", 64'(cnt0), 64'd0);
        @(posedge clk); #1 reset = 1'b1; clr();
        #1 check("lit_after_rst", 64'({sm[0], me[0]}), 64'd0);
        check("lit_after_rst_cnt", 64'(cnt0), 64'd0);

        @(posedge clk); #1 clr();
        ra_e[3:0] = 4'd3; ve = 3'b001; wa_m = 4'd3; wa_w = 4'd3; rwm = 1; rww = 1;
        #1 check("lit_fwd_m", 64'(fwd[0][1:0]), 64'h2);
        rwm = 0;
        #1 check("lit_fwd_w", 64'(fwd[0][1:0]), 64'h1);
        rwm = 1; mtrm = 1;
        #1 check("lit_fwd_load_m", 64'(fwd[0][1:0]), 64'h1);

        @(posedge clk); #1 clr();
        mtre = 1; rwe = 1; wa_e = 4'd5; ra_d[11:8] = 4'd5; vd = 3'b100;
        #1 check("lit_lduse0", 64'({sf[0], sd[0], fe[0]}), 64'h7);
        check("lit_lduse1", 64'({sf[1], sd[1], fe[1]}), 64'h7);
        @(posedge clk); #1 clr();
        wa_w = 4'd5; rww = 1; ra_e[11:8] = 4'd5; ve = 3'b100;
        #1 check("lit_lduse_fwd", 64'(fwd[0][5:4]), 64'h1);

        @(posedge clk); #1 clr();
        mtre = 1; rwe = 1; wa_e = 4'd0; vd = 3'b001;
        #1 check("lit_zero_on", 64'(sd[1]), 64'd0);
        check("lit_zero_off", 64'(sd[0]), 64'd1);

        pct = 90;
        for (int c = 0; c < 3000; c++) begin
            case ((c / 200) % 3)
                0:       pct = 90;
                1:       pct = 40;
                default: pct = 3;
            endcase
            @(posedge clk); #1;
            reset = ($urandom_range(0, 399) != 0);
            for (int i = 0; i < 3; i++) begin
                ra_d[4*i +: 4] = 4'($urandom_range(0, 3));
                ra_e[4*i +: 4] = 4'($urandom_range(0, 3));
            end
            vd = 3'($urandom); ve = 3'($urandom);
            wa_e = 4'($urandom_range(0, 3)); wa_m = 4'($urandom_range(0, 3)); wa_w = 4'($urandom_range(0, 3));
            rwe = 1'($urandom); rwm = 1'($urandom); rww = 1'($urandom);
            mtre = ($urandom_range(0, 3) == 0); mtrm = ($urandom_range(0, 2) == 0);
            macc = ($urandom_range(0, 3) == 0);
            mrdy = ($urandom_range(0, 99) < pct);
            btk = 1'($urandom); pred = 1'($urandom);
            pcsrc = ($urandom_range(0, 7) == 0); pcwp = ($urandom_range(0, 7) == 0);
        end
        @(posedge clk); #1 reset = 1'b1; clr();
        repeat (2) @(posedge clk);
        #1 $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
